pc_unit: RTL and testbench

- Parametrised program-counter unit for the MIPS core; successor to the single-register PC.
- Holds the fetch address and selects the next address from: sequential increment, branch/jump redirect, call with a hardware return-address stack (RAS), return, exception vector, and stall.
- Sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/pc_if.sv | 34 +++
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_if.sv
// Fetch-control bundle between the front-end sequencer (master) and the PC unit (slave).
interface pc_if #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             exc_valid;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_target;
  logic             call_valid;
  logic [WIDTH-1:0] call_target;
  logic             ret_valid;
  logic [WIDTH-1:0] ret_target;
  logic [WIDTH-1:0] pc_now;
  logic [WIDTH-1:0] pc_plus;
  logic [CW-1:0]    ras_count;
  logic             misalign;
  logic             ras_overflow;
  logic             ras_underflow;

  modport master (
    output stall, exc_valid, redirect_valid, redirect_target,
           call_valid, call_target, ret_valid, ret_target,
    input  pc_now, pc_plus, ras_count, misalign, ras_overflow, ras_underflow
  );

  modport slave (
    input  stall, exc_valid, redirect_valid, redirect_target,
           call_valid, call_target, ret_valid, ret_target,
    output pc_now, pc_plus, ras_count, misalign, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter with next-address select and a circular return-address stack.
// One-cycle latency from request to pc_now; stall holds PC and RAS, exception overrides stall.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter int               STEP       = 4,
  parameter logic [WIDTH-1:0] RESET_VEC  = '0,
  parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(32'h0000_0180),
  parameter int               ALIGN_BITS = 2,
  parameter int               RAS_DEPTH  = 4
) (
  input logic  clk,
  input logic  rst,
  pc_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  // Zero when ALIGN_BITS==0, which disables both clearing and the misalign flag.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    top_idx;
  logic [CW-1:0]    cnt_q;
  logic             take;
  logic             push;
  logic             pop;
  logic             full;
  logic             mis_d;
  logic             unf_d;
  logic             mis_q;
  logic             ovf_q;
  logic             unf_q;

  assign pc_plus = pc_q + WIDTH'(STEP);
  // ptr_q is the next free slot; the newest entry sits just below it.
  assign top_idx = ptr_q - PW'(1);
  assign full    = (cnt_q == CW'(RAS_DEPTH));

  always_comb begin
    pc_d  = pc_plus;
    tgt   = '0;
    take  = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    unf_d = 1'b0;
    if (bus.exc_valid) begin
      pc_d = EXC_VEC;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.redirect_valid) begin
      tgt  = bus.redirect_target;
      take = 1'b1;
    end else if (bus.call_valid) begin
      tgt  = bus.call_target;
      take = 1'b1;
      push = 1'b1;
    end else if (bus.ret_valid) begin
      take = 1'b1;
      if (cnt_q != '0) begin
        tgt = ras_q[top_idx];
        pop = 1'b1;
      end else begin
        tgt   = bus.ret_target;
        unf_d = 1'b1;
      end
    end
    if (take) begin
      pc_d = tgt & ~ALIGN_MASK;
    end
    mis_d = take & (|(tgt & ALIGN_MASK));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ptr_q <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
      ovf_q <= push & full;
      unf_q <= unf_d;
      if (push) begin
        // When full, the slot at ptr_q holds the oldest entry and is overwritten.
        ras_q[ptr_q] <= pc_plus;
        ptr_q        <= ptr_q + PW'(1);
        if (!full) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else if (pop) begin
        ptr_q <= top_idx;
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign bus.pc_now        = pc_q;
  assign bus.pc_plus       = pc_plus;
  assign bus.ras_count     = cnt_q;
  assign bus.misalign      = mis_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Scenario bench for pc_unit: default instance plus one with a high reset vector for wrap tests.
module tb_pc_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        mis;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct packed {
    logic        rs;
    logic        st;
    logic        ex;
    logic        rv;
    logic        cv;
    logic        tv;
    logic [31:0] tgt;
  } stim_t;

  localparam logic [31:0] DEAD = 32'hDEAD_0000;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  pc_if #(.WIDTH(32), .RAS_DEPTH(4)) bus();
  pc_if #(.WIDTH(32), .RAS_DEPTH(4)) bus_hi();

  pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'h0), .EXC_VEC(32'h180),
            .ALIGN_BITS(2), .RAS_DEPTH(4))
    u_dut (.clk(clk), .rst(rst), .bus(bus));

  pc_unit #(.WIDTH(32), .STEP(4), .RESET_VEC(32'hFFFF_FFF8), .EXC_VEC(32'h180),
            .ALIGN_BITS(2), .RAS_DEPTH(4))
    u_hi (.clk(clk), .rst(rst), .bus(bus_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic stim_t sv(logic rs, logic st, logic ex, logic rv, logic cv, logic tv,
                               logic [31:0] tgt);
    return '{rs: rs, st: st, ex: ex, rv: rv, cv: cv, tv: tv, tgt: tgt};
  endfunction

  function automatic exp_t ev(logic [31:0] pc, logic [2:0] cnt, logic mis, logic ovf, logic unf);
    return '{pc: pc, cnt: cnt, mis: mis, ovf: ovf, unf: unf};
  endfunction

  function automatic exp_t obs(bit hi);
    if (hi) return {bus_hi.pc_now, bus_hi.ras_count, bus_hi.misalign,
                    bus_hi.ras_overflow, bus_hi.ras_underflow};
    return {bus.pc_now, bus.ras_count, bus.misalign, bus.ras_overflow, bus.ras_underflow};
  endfunction

  function automatic string fmt(exp_t v);
    return $sformatf("pc=%h cnt=%0d mis=%b ovf=%b unf=%b", v.pc, v.cnt, v.mis, v.ovf, v.unf);
  endfunction

  task automatic apply(stim_t s, bit hi);
    rst = s.rs;
    if (hi) begin
      bus_hi.stall = s.st; bus_hi.exc_valid = s.ex;
      bus_hi.redirect_valid = s.rv; bus_hi.redirect_target = s.tgt;
      bus_hi.call_valid = s.cv; bus_hi.call_target = s.tgt;
      bus_hi.ret_valid = s.tv; bus_hi.ret_target = s.tgt;
    end else begin
      bus.stall = s.st; bus.exc_valid = s.ex;
      bus.redirect_valid = s.rv; bus.redirect_target = s.tgt;
      bus.call_valid = s.cv; bus.call_target = s.tgt;
      bus.ret_valid = s.tv; bus.ret_target = s.tgt;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    // Reset must win over every request on the main instance.
    apply(sv(1, 1, 1, 1, 1, 1, 32'h40), 0);
    apply(sv(1, 0, 0, 0, 1, 0, 32'h40), 1);
    exp_q.push_back(ev(32'h0, 0, 0, 0, 0));
    exp_q.push_back(ev(32'hFFFF_FFF8, 0, 0, 0, 0));
    tick(); tick();
    e = exp_q.pop_front(); o = obs(0); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_main: got %s want %s", fmt(o), fmt(e)); end
    e = exp_q.pop_front(); o = obs(1); checks++;
    if (o !== e) begin failures++; $display("FAIL reset_hi: got %s want %s", fmt(o), fmt(e)); end
    checks++;
    if (bus.pc_plus !== 32'h4) begin
      failures++; $display("FAIL reset_pc_plus: got %h want 00000004", bus.pc_plus);
    end
  endtask

  task automatic test_free_run();
    exp_t e, o;
    apply(sv(0, 0, 0, 0, 0, 0, 0), 1);
    for (int i = 1; i <= 3; i++) begin
      apply(sv(0, 0, 0, 0, 0, 0, 0), 0);
      exp_q.push_back(ev(32'(i * 4), 0, 0, 0, 0));
      tick();
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin failures++; $display("FAIL free_run[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
    checks++;
    if (bus.pc_plus !== 32'h10) begin
      failures++; $display("FAIL free_run_pc_plus: got %h want 00000010", bus.pc_plus);
    end
  endtask

  task automatic run_main(string name, stim_t s[$], exp_t x[$]);
    // Drives the stimulus list and queues expectations; checks live in each scenario.
    foreach (s[i]) begin
      apply(s[i], 0);
      exp_q.push_back(x[i]);
      tick();
    end
  endtask

  task automatic test_stall();
    stim_t s[$]; exp_t x[$]; exp_t e, o;
    s = '{sv(0,0,0,1,0,0,32'h8),   sv(0,1,0,1,0,0,32'h100), sv(0,1,0,1,0,0,32'h100),
          sv(0,0,0,1,0,0,32'h100), sv(0,0,0,0,0,0,0)};
    x = '{ev(32'h8,0,0,0,0),   ev(32'h8,0,0,0,0), ev(32'h8,0,0,0,0),
          ev(32'h100,0,0,0,0), ev(32'h104,0,0,0,0)};
    foreach (s[i]) begin
      apply(s[i], 0); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin failures++; $display("FAIL stall[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_call_ret();
    stim_t s[$]; exp_t x[$]; exp_t e, o;
    s = '{sv(0,0,0,1,0,0,32'h20), sv(0,0,0,0,1,0,32'h400), sv(0,0,0,0,0,1,DEAD),
          sv(0,0,0,0,0,1,32'h88), sv(0,0,0,0,0,0,0)};
    x = '{ev(32'h20,0,0,0,0), ev(32'h400,1,0,0,0), ev(32'h24,0,0,0,0),
          ev(32'h88,0,0,0,1), ev(32'h8C,0,0,0,0)};
    foreach (s[i]) begin
      apply(s[i], 0); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin failures++; $display("FAIL call_ret[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_overflow();
    stim_t s[$]; exp_t x[$]; exp_t e, o;
    s = '{sv(0,0,0,1,0,0,32'h0),
          sv(0,0,0,0,1,0,32'h100), sv(0,0,0,0,1,0,32'h200), sv(0,0,0,0,1,0,32'h300),
          sv(0,0,0,0,1,0,32'h400), sv(0,0,0,0,1,0,32'h500),
          sv(0,0,0,0,0,1,DEAD), sv(0,0,0,0,0,1,DEAD), sv(0,0,0,0,0,1,DEAD),
          sv(0,0,0,0,0,1,DEAD), sv(0,0,0,0,0,1,32'h900)};
    x = '{ev(32'h0,0,0,0,0),
          ev(32'h100,1,0,0,0), ev(32'h200,2,0,0,0), ev(32'h300,3,0,0,0),
          ev(32'h400,4,0,0,0), ev(32'h500,4,0,1,0),
          ev(32'h404,3,0,0,0), ev(32'h304,2,0,0,0), ev(32'h204,1,0,0,0),
          ev(32'h104,0,0,0,0), ev(32'h900,0,0,0,1)};
    foreach (s[i]) begin
      apply(s[i], 0); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin failures++; $display("FAIL overflow[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_exception();
    stim_t s[$]; exp_t x[$]; exp_t e, o;
    s = '{sv(0,0,0,0,1,0,32'h40),  sv(0,1,1,1,1,1,32'h7770), sv(0,0,0,1,0,0,32'h1003),
          sv(0,0,0,0,0,0,0),       sv(0,0,0,0,0,1,DEAD),     sv(0,0,0,0,1,0,32'h2002),
          sv(0,0,0,0,0,1,DEAD),    sv(0,0,0,0,0,1,32'h3001), sv(0,1,0,0,0,0,0),
          sv(0,0,1,0,0,0,0)};
    x = '{ev(32'h40,1,0,0,0),   ev(32'h180,1,0,0,0), ev(32'h1000,1,1,0,0),
          ev(32'h1004,1,0,0,0), ev(32'h904,0,0,0,0), ev(32'h2000,1,1,0,0),
          ev(32'h908,0,0,0,0),  ev(32'h3000,0,1,0,1), ev(32'h3000,0,0,0,0),
          ev(32'h180,0,0,0,0)};
    foreach (s[i]) begin
      apply(s[i], 0); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); o = obs(0); checks++;
      if (o !== e) begin failures++; $display("FAIL exception[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_wrap_reset();
    stim_t s[$]; exp_t x[$]; exp_t e, o;
    apply(sv(0, 0, 0, 0, 0, 0, 0), 0);
    s = '{sv(1,0,0,0,0,0,0),       sv(0,0,0,0,0,0,0),       sv(0,0,0,0,0,0,0),
          sv(0,0,0,0,1,0,32'h40),  sv(0,0,0,0,1,0,32'h80),  sv(1,0,0,0,1,0,32'h100),
          sv(0,0,0,0,0,1,32'h500)};
    x = '{ev(32'hFFFF_FFF8,0,0,0,0), ev(32'hFFFF_FFFC,0,0,0,0), ev(32'h0,0,0,0,0),
          ev(32'h40,1,0,0,0),        ev(32'h80,2,0,0,0),        ev(32'hFFFF_FFF8,0,0,0,0),
          ev(32'h500,0,0,0,1)};
    foreach (s[i]) begin
      apply(s[i], 1); exp_q.push_back(x[i]); tick();
      e = exp_q.pop_front(); o = obs(1); checks++;
      if (o !== e) begin failures++; $display("FAIL wrap_reset[%0d]: got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    apply(sv(1, 0, 0, 0, 0, 0, 0), 0);
    apply(sv(1, 0, 0, 0, 0, 0, 0), 1);
    test_reset();
    test_free_run();
    test_stall();
    test_call_ret();
    test_overflow();
    test_exception();
    test_wrap_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
